// File: rtl/systolic_pkg.sv
// Shared constants and FSM state type for the systolic feeder.
// Default array geometry, element width and vector-count width.
package systolic_pkg;

  localparam int DATA_WIDTH           = 16;
  localparam int SYSTOLIC_ARRAY_WIDTH = 2;
  localparam int ROW_CNT_WIDTH        = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// Fixed-depth shift register used to skew one array lane.
// Ports: clk, rst_n, d (lane in), q (lane in delayed DEPTH cycles).
module skew_delay #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_sr
    logic [DATA_WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) begin
          sr[k] <= '0;
        end
      end else begin
        sr[0] <= d;
        for (int k = 1; k < DEPTH; k++) begin
          sr[k] <= sr[k-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds weights (north) and skewed input vectors (west) to the array.
// Ports: cmd/w/in valid-ready inputs, sys_* array drives, ub col size, busy/done.
module systolic_feeder #(
  parameter int SYSTOLIC_ARRAY_WIDTH = systolic_pkg::SYSTOLIC_ARRAY_WIDTH,
  parameter int DATA_WIDTH           = systolic_pkg::DATA_WIDTH,
  parameter int ROW_CNT_WIDTH        = systolic_pkg::ROW_CNT_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [ROW_CNT_WIDTH-1:0]                   cmd_num_rows,
  input  logic [15:0]                                cmd_col_size,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] w_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] sys_data_in,
  output logic                                       sys_start,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] sys_weight_in,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]            sys_accept_w,
  output logic                                       sys_switch_in,
  output logic [15:0]                                ub_rd_col_size_out,
  output logic                                       ub_rd_col_size_valid_out,
  output logic                                       busy,
  output logic                                       done
);

  import systolic_pkg::*;

  localparam int N          = SYSTOLIC_ARRAY_WIDTH;
  localparam int WCW        = $clog2(N + 1);
  localparam int DRAIN_LAST = (N > 1) ? N - 2 : 0;
  localparam int DCW        = (N > 2) ? $clog2(N - 1) : 1;

  feeder_state_t state, state_nxt;

  logic [ROW_CNT_WIDTH-1:0] num_rows_q;
  logic [ROW_CNT_WIDTH-1:0] rcnt;
  logic [ROW_CNT_WIDTH-1:0] rcnt_inc;
  logic [15:0]              col_size_q;
  logic [WCW-1:0]           wcnt;
  logic [DCW-1:0]           dcnt;
  logic [N*DATA_WIDTH-1:0]  in_q;

  logic cmd_fire, w_fire, in_fire;
  logic w_last, in_last, drain_last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign w_ready   = (state == LOAD_W);
  assign in_ready  = (state == STREAM) && (rcnt != num_rows_q);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign w_fire   = w_valid && w_ready;
  assign in_fire  = in_valid && in_ready;

  // Exit on equality so a full-scale count never needs a wider counter.
  assign rcnt_inc   = rcnt + ROW_CNT_WIDTH'(1);
  assign w_last     = w_fire && (wcnt == WCW'(N - 1));
  assign in_last    = in_fire && (rcnt_inc == num_rows_q);
  assign drain_last = (dcnt == DCW'(DRAIN_LAST));

  assign ub_rd_col_size_out = col_size_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_fire) state_nxt = LOAD_W;
      LOAD_W:  if (w_last) state_nxt = SWITCH;
      SWITCH:  state_nxt = (num_rows_q == '0) ? DRAIN : STREAM;
      STREAM:  if (in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_rows_q               <= '0;
      col_size_q               <= '0;
      ub_rd_col_size_valid_out <= 1'b0;
      wcnt                     <= '0;
      rcnt                     <= '0;
      dcnt                     <= '0;
      sys_weight_in            <= '0;
      sys_accept_w             <= '0;
      sys_switch_in            <= 1'b0;
      done                     <= 1'b0;
      in_q                     <= '0;
      sys_start                <= 1'b0;
    end else begin
      ub_rd_col_size_valid_out <= cmd_fire;
      if (cmd_fire) begin
        num_rows_q <= cmd_num_rows;
        col_size_q <= cmd_col_size;
        wcnt       <= '0;
        rcnt       <= '0;
      end
      if (w_fire) begin
        wcnt          <= wcnt + WCW'(1);
        sys_weight_in <= w_data;
      end
      sys_accept_w  <= w_fire ? '1 : '0;
      // Switch lands the cycle after the last accept strobe.
      sys_switch_in <= (state == SWITCH);
      if (in_fire) rcnt <= rcnt_inc;
      dcnt <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
      done <= (state == DRAIN) && drain_last;
      // Skew pipeline never stalls; idle cycles become zero bubbles.
      in_q      <= in_fire ? in_data : '0;
      sys_start <= in_fire;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(
      .DEPTH      (i),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .q     (sys_data_in[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=2, 16-bit lanes).
// Table-driven main pass plus gap, zero-row and mid-pass reset sequences.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_num_rows;
  logic [15:0] cmd_col_size;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] sys_data_in;
  logic        sys_start;
  logic [31:0] sys_weight_in;
  logic [1:0]  sys_accept_w;
  logic        sys_switch_in;
  logic [15:0] ub_col;
  logic        ub_valid;
  logic        busy;
  logic        done;

  systolic_feeder dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_num_rows             (cmd_num_rows),
    .cmd_col_size             (cmd_col_size),
    .w_valid                  (w_valid),
    .w_ready                  (w_ready),
    .w_data                   (w_data),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_data                  (in_data),
    .sys_data_in              (sys_data_in),
    .sys_start                (sys_start),
    .sys_weight_in            (sys_weight_in),
    .sys_accept_w             (sys_accept_w),
    .sys_switch_in            (sys_switch_in),
    .ub_rd_col_size_out       (ub_col),
    .ub_rd_col_size_valid_out (ub_valid),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [15:0] nr;
    logic [15:0] cs;
    logic        wv;
    logic [31:0] wd;
    logic        iv;
    logic [31:0] id;
    logic        e_cr;
    logic        e_wr;
    logic        e_ir;
    logic        e_bz;
    logic        e_dn;
    logic        e_ubv;
    logic [15:0] e_ubc;
    logic [1:0]  e_aw;
    logic [31:0] e_win;
    logic        e_sw;
    logic        e_st;
    logic [31:0] e_din;
  } vec_t;

  vec_t tbl [10];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [88:0] all_out();
    return {sys_data_in, sys_start, sys_weight_in, sys_accept_w,
            sys_switch_in, ub_col, ub_valid, busy, done,
            w_ready, in_ready};
  endfunction

  task automatic start_pass(input logic [15:0] rows,
                            input logic [15:0] col);
    chk("idle_ready", 128'(cmd_ready), 128'(1));
    cmd_valid    = 1'b1;
    cmd_num_rows = rows;
    cmd_col_size = col;
    tick();
    cmd_valid = 1'b0;
    chk("col_strobe", 128'({ub_valid, ub_col}), 128'({1'b1, col}));
    w_valid = 1'b1;
    w_data  = 32'h0004_0003;
    tick();
    w_data = 32'h0002_0001;
    tick();
    w_valid = 1'b0;
    chk("acc_w_last", 128'(sys_accept_w), 128'(2'b11));
    tick();
    chk("switch", 128'({sys_switch_in, sys_accept_w}), 128'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [7:0]  g_vld;
  logic [31:0] g_dat [8];
  logic [7:0]  g_st;
  logic [7:0]  g_ir;
  logic [7:0]  g_dn;
  logic [31:0] g_din [8];
  int          s_cyc;
  logic        saw_done;

  initial begin
    tbl[0] = '{1, 3, 2, 0, 0, 0, 0,
               1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 7, 9, 1, 32'h0004_0003, 1, 32'hdead_beef,
               0, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 7, 9, 1, 32'h0002_0001, 1, 32'hdead_beef,
               0, 1, 0, 1, 0, 0, 2, 3, 32'h0004_0003, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 1, 0, 0, 2, 3, 32'h0002_0001, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 1, 32'h0020_0010,
               0, 0, 1, 1, 0, 0, 2, 0, 32'h0002_0001, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 32'h0021_0011,
               0, 0, 1, 1, 0, 0, 2, 0, 32'h0002_0001, 0, 1,
               32'h0000_0010};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 32'h0022_0012,
               0, 0, 1, 1, 0, 0, 2, 0, 32'h0002_0001, 0, 1,
               32'h0020_0011};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 1, 0, 0, 2, 0, 32'h0002_0001, 0, 1,
               32'h0021_0012};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0,
               1, 0, 0, 0, 1, 0, 2, 0, 32'h0002_0001, 0, 0,
               32'h0022_0000};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0,
               1, 0, 0, 0, 0, 0, 2, 0, 32'h0002_0001, 0, 0, 0};

    g_vld = 8'b0001_1001;
    g_dat = '{32'h0020_0010, 0, 0, 32'h0021_0011,
              32'h0022_0012, 0, 0, 0};
    g_st  = 8'b0011_0010;
    g_ir  = 8'b0001_1111;
    g_dn  = 8'b0100_0000;
    g_din = '{0, 32'h0000_0010, 32'h0020_0000, 0,
              32'h0000_0011, 32'h0021_0012, 32'h0022_0000, 0};

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_num_rows = '0;
    cmd_col_size = '0;
    w_valid      = 1'b0;
    w_data       = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    tick();
    chk("rst_outs", 128'(all_out()), 128'(0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d", i),
          128'({cmd_ready, w_ready, in_ready, busy, done, ub_valid,
                ub_col, sys_accept_w, sys_weight_in, sys_switch_in,
                sys_start, sys_data_in}),
          128'({tbl[i].e_cr, tbl[i].e_wr, tbl[i].e_ir, tbl[i].e_bz,
                tbl[i].e_dn, tbl[i].e_ubv, tbl[i].e_ubc, tbl[i].e_aw,
                tbl[i].e_win, tbl[i].e_sw, tbl[i].e_st,
                tbl[i].e_din}));
      cmd_valid    = tbl[i].cv;
      cmd_num_rows = tbl[i].nr;
      cmd_col_size = tbl[i].cs;
      w_valid      = tbl[i].wv;
      w_data       = tbl[i].wd;
      in_valid     = tbl[i].iv;
      in_data      = tbl[i].id;
      tick();
    end

    // Two-cycle bubble between vectors 0 and 1.
    start_pass(16'd3, 16'd5);
    s_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("gap_st%0d", k), 128'(sys_start), 128'(g_st[k]));
      chk($sformatf("gap_din%0d", k), 128'(sys_data_in),
          128'(g_din[k]));
      chk($sformatf("gap_ir%0d", k), 128'(in_ready), 128'(g_ir[k]));
      chk($sformatf("gap_dn%0d", k), 128'(done), 128'(g_dn[k]));
      if (in_ready) s_cyc++;
      in_valid = g_vld[k];
      in_data  = g_dat[k];
      tick();
    end
    in_valid = 1'b0;
    chk("gap_stream_cycles", 128'(s_cyc), 128'(5));

    // Zero-row pass: switch, then done one cycle later, no data.
    start_pass(16'd0, 16'd1);
    chk("r0_drain",
        128'({sys_start, in_ready, done, busy}), 128'(4'b0001));
    tick();
    chk("r0_done",
        128'({sys_start, done, cmd_ready, busy}), 128'(4'b0110));
    tick();
    chk("r0_after", 128'({done, cmd_ready}), 128'(2'b01));

    // Reset in the middle of a stream.
    start_pass(16'd5, 16'd3);
    in_valid = 1'b1;
    in_data  = 32'h0044_0033;
    tick();
    tick();
    chk("pre_rst_start", 128'(sys_start), 128'(1));
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_outs%0d", k), 128'(all_out()), 128'(0));
      chk($sformatf("mid_rst_rdy%0d", k), 128'(cmd_ready), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_rdy", 128'({cmd_ready, busy}), 128'(2'b10));
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done || sys_start) saw_done = 1'b1;
      tick();
    end
    chk("post_rst_quiet", 128'(saw_done), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Drives the west and north edges of the systolic array.
- Accepts one command per matrix pass, then loads the pass's weight rows into the array's shadow buffers and pulses the switch signal.
- Then streams input vectors into the array rows with the diagonal skew the array requires.
- Also issues the column-enable size to the array; sits between the unified-buffer read side and the array.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 2, array rows = columns = lanes (N).
- DATA_WIDTH, 16, bits per element.
- ROW_CNT_WIDTH, 16, width of the vector-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  feeder idle, command accepted when both high
- cmd_num_rows  in  ROW_CNT_WIDTH  input vectors to stream (0 allowed)
- cmd_col_size  in  16  active columns, forwarded to array
- w_valid  in  1  weight row beat present
- w_ready  out  1  weight beat accepted when both high
- w_data  in  N*DATA_WIDTH  one weight row; lane j = column j, lane 0 in LSBs
- in_valid  in  1  input vector beat present
- in_ready  out  1  input beat accepted when both high
- in_data  in  N*DATA_WIDTH  one input vector; lane i = array row i
- sys_data_in  out  N*DATA_WIDTH  skewed west-edge data, lane i to row i
- sys_start  out  1  valid for row-0 lane
- sys_weight_in  out  N*DATA_WIDTH  north-edge weights, lane j to column j
- sys_accept_w  out  N  per-column weight-accept
- sys_switch_in  out  1  shadow-to-active switch pulse
- ub_rd_col_size_out  out  16  column size
- ub_rd_col_size_valid_out  out  1  one-cycle strobe
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0 except cmd_ready=1. State IDLE, counters and skew registers cleared. Reset mid-pass abandons the pass immediately; no done pulse.
- IDLE:
  - cmd_ready=1.
  - On command accept, latch num_rows and col_size.
  - Next cycle: ub_rd_col_size_valid_out=1 for one cycle with ub_rd_col_size_out=col_size; go to LOAD_W.
- LOAD_W:
  - w_ready=1 while weight count < N.
  - Each accepted beat drives sys_weight_in=w_data and sys_accept_w=all ones on the next cycle (registered, latency 1). Otherwise sys_accept_w=0 and sys_weight_in holds its value.
  - Beats arrive last array row first: beat k lands in row N-1-k after N beats.
  - After the Nth beat go to SWITCH.
- SWITCH: sys_switch_in=1 for exactly one cycle, aligned with the cycle after the last sys_accept_w. If num_rows=0 go to DRAIN, else go to STREAM.
- STREAM:
  - in_ready=1 while accepted count < num_rows.
  - Accepted beat at cycle t: lane i appears on sys_data_in lane i at cycle t+1+i.
  - sys_start is the skew-0 valid: 1 at t+1.
  - Cycle with in_valid=0 inserts a bubble: zero data, sys_start=0, skewed the same way.
  - The array has no backpressure, so the skew pipeline always advances.
  - After the last accept go to DRAIN.
- DRAIN:
  - Skew pipeline keeps shifting in zeros.
  - After N-1 further cycles (last lane emitted), done=1 for one cycle and state returns to IDLE. cmd_ready=1 in the same cycle as done.
- Skew registers: lane i uses an i-deep shift register of DATA_WIDTH. Lane 0 uses a single output register.
- Busy rules: cmd_valid while busy is ignored (cmd_ready=0). w_ready=0 outside LOAD_W; in_ready=0 outside STREAM.
- Simultaneous events: w_valid during STREAM is not accepted; in_valid during LOAD_W is not accepted. Both are held off by their ready.
- Counter width: num_rows counts up to 2^ROW_CNT_WIDTH-1 with no wrap. The STREAM exit compare is on equality.

Decomposition:
- Package systolic_pkg holds DATA_WIDTH, SYSTOLIC_ARRAY_WIDTH defaults and the feeder_state_t enum (IDLE, LOAD_W, SWITCH, STREAM, DRAIN).
- One sub-module skew_delay (parameters DEPTH, DATA_WIDTH), instantiated per lane with DEPTH=i. It is also reused to skew valid if needed.

Test Plan:
- Reset mid-STREAM, rst_n low 3 cycles: all outputs 0, cmd_ready=1 the cycle after release, no done pulse.
- Command with num_rows=3, col_size=2; weights {0x0004,0x0003} then {0x0002,0x0001}:
  - ub_rd_col_size_valid pulses with value 2 on cycle 1.
  - sys_accept_w=2'b11 for 2 cycles, then sys_switch_in one cycle after.
- Stream vectors {0x0010,0x0020},{0x0011,0x0021},{0x0012,0x0022} back-to-back:
  - lane0 emits 0x10,0x11,0x12 at t+1..t+3.
  - lane1 emits 0x20,0x21,0x22 at t+2..t+4.
  - sys_start high 3 cycles.
  - done pulses at t+4.
- in_valid gap of 2 cycles between vectors 1 and 2: sys_start low 2 cycles, lane1 shows the same 2 zero bubbles one cycle later, total stream cycles = 5.
- num_rows=0: weights loaded, switch pulsed, no sys_start, done pulses N-1 cycles after SWITCH.
- Busy rejection and blocked beats:
  - cmd_valid during LOAD_W keeps cmd_ready=0 and leaves latched values unchanged.
  - in_valid during LOAD_W: in_ready=0, nothing emitted.
